vec_to_phase: RTL and testbench

VEC_TO_PHASE -- requirements
Module: vec_to_phase

---
 rtl/cordic_pkg.sv | 46 ++++
 rtl/cordic_atan_rom.sv | 11 +
 rtl/vec_to_phase.sv | 133 +++++++++++++
 tb/tb_vec_to_phase.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC types, widths and the arctangent table.
// Used by both the rotation (sin_cos) and vectoring (vec_to_phase) blocks.
package cordic_pkg;

    localparam int ANGLE_W = 16;
    localparam int PHASE_W = 10;
    localparam int DATA_W  = 18;
    localparam int XY_W    = 21;
    localparam int MAG_W   = 20;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FOLD,
        S_ITER,
        S_OUT
    } state_t;

    // round(atan(2^-i) * 65536 / (2*pi))
    function automatic logic [ANGLE_W-1:0] atan_lut(
        input logic [IDX_W-1:0] idx
    );
        logic [ANGLE_W-1:0] v;
        v = '0;
        unique case (idx)
            4'd0:  v = 16'd8192;
            4'd1:  v = 16'd4836;
            4'd2:  v = 16'd2555;
            4'd3:  v = 16'd1297;
            4'd4:  v = 16'd651;
            4'd5:  v = 16'd326;
            4'd6:  v = 16'd163;
            4'd7:  v = 16'd81;
            4'd8:  v = 16'd41;
            4'd9:  v = 16'd20;
            4'd10: v = 16'd10;
            4'd11: v = 16'd5;
            4'd12: v = 16'd3;
            4'd13: v = 16'd1;
            4'd14: v = 16'd1;
            4'd15: v = 16'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table lookup, one entry per CORDIC step.
module cordic_atan_rom
    import cordic_pkg::*;
(
    input  logic [IDX_W-1:0]   i_idx,
    output logic [ANGLE_W-1:0] o_atan
);

    assign o_atan = atan_lut(i_idx);

endmodule

// File: rtl/vec_to_phase.sv
// CORDIC vectoring engine: (x, y) -> atan2 phase and gain-scaled magnitude.
// One iteration per cycle; left-half-plane inputs are folded first.
module vec_to_phase
    import cordic_pkg::*;
#(
    parameter int ITERS = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [DATA_W-1:0]  x_in,
    input  logic [DATA_W-1:0]  y_in,
    output logic               busy,
    output logic               done,
    output logic [PHASE_W-1:0] phase,
    output logic [MAG_W-1:0]   mag
);

    state_t r_state;
    state_t w_next;

    logic signed [XY_W-1:0] r_x;
    logic signed [XY_W-1:0] r_y;
    logic [ANGLE_W-1:0]     r_acc;
    logic [IDX_W-1:0]       r_cnt;
    logic                   r_zero;
    logic                   r_done;
    logic [PHASE_W-1:0]     r_phase;
    logic [MAG_W-1:0]       r_mag;

    logic [ANGLE_W-1:0]     w_atan;
    logic                   w_last;
    logic                   w_ypos;
    logic signed [XY_W-1:0] w_xsh;
    logic signed [XY_W-1:0] w_ysh;
    logic signed [XY_W-1:0] w_xi;
    logic signed [XY_W-1:0] w_yi;
    logic [ANGLE_W-1:0]     w_acci;
    logic [ANGLE_W-1:0]     w_rnd;
    logic [PHASE_W-1:0]     w_phase;

    cordic_atan_rom u_rom (
        .i_idx  (r_cnt),
        .o_atan (w_atan)
    );

    assign w_last = (r_cnt == IDX_W'(ITERS - 1));
    assign w_ypos = ~r_y[XY_W-1];
    assign w_xsh  = r_x >>> r_cnt;
    assign w_ysh  = r_y >>> r_cnt;
    assign w_xi   = w_ypos ? r_x + w_ysh : r_x - w_ysh;
    assign w_yi   = w_ypos ? r_y - w_xsh : r_y + w_xsh;
    assign w_acci = w_ypos ? r_acc + w_atan : r_acc - w_atan;

    // Round to the nearest of 1024 phase steps; zero vector has no angle.
    assign w_rnd   = r_acc + ANGLE_W'(32);
    assign w_phase = r_zero ? '0 : w_rnd[ANGLE_W-1:ANGLE_W-PHASE_W];

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_next = S_FOLD;
            S_FOLD: w_next = S_ITER;
            S_ITER: if (w_last) w_next = S_OUT;
            S_OUT:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_zero  <= 1'b0;
            r_done  <= 1'b0;
            r_phase <= '0;
            r_mag   <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x    <= {{(XY_W-DATA_W){x_in[DATA_W-1]}}, x_in};
                        r_y    <= {{(XY_W-DATA_W){y_in[DATA_W-1]}}, y_in};
                        r_zero <= (x_in == '0) && (y_in == '0);
                        r_acc  <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_FOLD: begin
                    // Rotate by pi so iterations only see the right half-plane.
                    if (r_x[XY_W-1]) begin
                        r_x   <= -r_x;
                        r_y   <= -r_y;
                        r_acc <= 16'h8000;
                    end else begin
                        r_acc <= '0;
                    end
                end
                S_ITER: begin
                    r_x   <= w_xi;
                    r_y   <= w_yi;
                    r_acc <= w_acci;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_OUT: begin
                    r_phase <= w_phase;
                    r_mag   <= r_x[MAG_W-1:0];
                    r_done  <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = (r_state != S_IDLE) | r_done;
    assign done  = r_done;
    assign phase = r_phase;
    assign mag   = r_mag;

endmodule

// File: tb/tb_vec_to_phase.sv
// Self-checking bench for vec_to_phase: directed cases, loopback sweep,
// random vectors, start re-pulse and mid-operation reset.
module tb_vec_to_phase;

    localparam int    ITERS = 14;
    localparam int    LAT   = ITERS + 2;
    localparam real   PI    = 3.14159265358979;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [17:0] x_in  = '0;
    logic [17:0] y_in  = '0;
    logic        busy;
    logic        done;
    logic [9:0]  phase;
    logic [19:0] mag;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vec_to_phase #(.ITERS(ITERS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x_in  (x_in),
        .y_in  (y_in),
        .busy  (busy),
        .done  (done),
        .phase (phase),
        .mag   (mag)
    );

    function automatic int atan_units(input int i);
        real r;
        r = $atan(1.0 / (2.0 ** i)) * 65536.0 / (2.0 * PI);
        return $rtoi(r + 0.5);
    endfunction

    // Vectoring rules in plain integer arithmetic.
    function automatic void model(input int xi, input int yi,
                                  output int ph, output int mg);
        int x, y, acc, xn;
        x = xi;
        y = yi;
        acc = 0;
        if (xi == 0 && yi == 0) begin
            ph = 0;
            mg = 0;
            return;
        end
        if (x < 0) begin
            x = -x;
            y = -y;
            acc = 32768;
        end
        for (int i = 0; i < ITERS; i++) begin
            if (y >= 0) begin
                xn = x + (y >>> i);
                y  = y - (x >>> i);
                acc = acc + atan_units(i);
            end else begin
                xn = x - (y >>> i);
                y  = y + (x >>> i);
                acc = acc - atan_units(i);
            end
            x = xn;
        end
        acc = acc & 32'hFFFF;
        ph = ((acc + 32) >> 6) & 1023;
        mg = x & 32'hFFFFF;
    endfunction

    function automatic int ref_phase(input int xi, input int yi);
        real a;
        int  p;
        a = $atan2(real'(yi), real'(xi)) * 1024.0 / (2.0 * PI);
        p = $rtoi($floor(a + 0.5));
        return ((p % 1024) + 1024) % 1024;
    endfunction

    task automatic chk_eq(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp,
                           input int tol);
        int d;
        bit ok;
        d  = (((obs - exp) % 1024) + 1024) % 1024;
        ok = (d <= tol) || (d >= 1024 - tol);
        checks++;
        assert (ok) else begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d+/-%0d",
                     tag, obs, exp, tol);
        end
    endtask

    // Issue one operation; inputs are scrambled after accept, and start is
    // optionally re-pulsed at the given cycle offsets.
    task automatic run_op(input int xi, input int yi, input bit now,
                          input int p1, input int p2,
                          output int ph, output int mg, output int lat);
        int a;
        if (!now) @(negedge clk);
        x_in  = 18'(xi);
        y_in  = 18'(yi);
        start = 1'b1;
        a     = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        x_in  = 18'($urandom);
        y_in  = 18'($urandom);
        chk_eq("busy_after_accept", int'(busy), 1);
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            if (done) begin
                lat = cyc - a;
                break;
            end
            start = (p1 != 0 && cyc - a == p1) || (p2 != 0 && cyc - a == p2);
            if (start) begin
                x_in = 18'($urandom);
                y_in = 18'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        ph = int'(phase);
        mg = int'(mag);
    endtask

    int dx[7] = '{131071, 0, -131072, 0, 92682, -92682, 0};
    int dy[7] = '{0, 131071, 0, -131072, 92682, -92682, 0};
    int dp[7] = '{0, 256, 512, 768, 128, 640, 0};
    int dt[7] = '{0, 0, 0, 0, 1, 1, 0};

    initial begin
        int ph, mg, lat, eph, emg, nd, xi, yi;
        real ang, mref;

        #2 rst_n = 1'b0;
        #1;
        chk_eq("rst_busy", int'(busy), 0);
        chk_eq("rst_done", int'(done), 0);
        chk_eq("rst_phase", int'(phase), 0);
        chk_eq("rst_mag", int'(mag), 0);

        @(negedge clk);
        rst_n = 1'b1;
        run_op(dx[0], dy[0], 1'b1, 0, 0, ph, mg, lat);
        model(dx[0], dy[0], eph, emg);
        chk_eq("first_lat", lat, LAT);
        chk_eq("first_phase", ph, dp[0]);
        chk_eq("first_mag_model", mg, emg);
        mref = 1.64676 * 131071.0;
        chk_tol("first_mag_near_gain", (mg - $rtoi(mref)) & 1023, 0, 8);
        @(negedge clk);
        chk_eq("done_one_cycle", int'(done), 0);
        chk_eq("phase_hold", int'(phase), ph);
        chk_eq("mag_hold", int'(mag), mg);

        for (int k = 1; k < 7; k++) begin
            run_op(dx[k], dy[k], 1'b0, 0, 0, ph, mg, lat);
            model(dx[k], dy[k], eph, emg);
            chk_eq($sformatf("dir%0d_lat", k), lat, LAT);
            chk_tol($sformatf("dir%0d_phase", k), ph, dp[k], dt[k]);
            chk_eq($sformatf("dir%0d_phase_model", k), ph, eph);
            chk_eq($sformatf("dir%0d_mag_model", k), mg, emg);
        end

        for (int t = 0; t < 1024; t++) begin
            ang = 2.0 * PI * real'(t) / 1024.0;
            xi = $rtoi($floor(131071.0 * $cos(ang) + 0.5));
            yi = $rtoi($floor(131071.0 * $sin(ang) + 0.5));
            run_op(xi, yi, 1'b0, 0, 0, ph, mg, lat);
            model(xi, yi, eph, emg);
            chk_tol($sformatf("loop%0d_phase", t), ph, t, 1);
            chk_eq($sformatf("loop%0d_mag", t), mg, emg);
        end

        for (int r = 0; r < 40; r++) begin
            for (int tries = 0; tries < 100; tries++) begin
                xi = int'($urandom_range(0, 262143)) - 131072;
                yi = int'($urandom_range(0, 262143)) - 131072;
                if (longint'(xi) * xi + longint'(yi) * yi >= 1048576) break;
            end
            run_op(xi, yi, 1'b0, 0, 0, ph, mg, lat);
            model(xi, yi, eph, emg);
            chk_eq($sformatf("rnd%0d_lat", r), lat, LAT);
            chk_tol($sformatf("rnd%0d_atan2", r), ph, ref_phase(xi, yi), 1);
            chk_eq($sformatf("rnd%0d_phase_model", r), ph, eph);
            chk_eq($sformatf("rnd%0d_mag_model", r), mg, emg);
        end

        run_op(0, 131071, 1'b0, 3, 10, ph, mg, lat);
        model(0, 131071, eph, emg);
        chk_eq("repulse_lat", lat, LAT);
        chk_eq("repulse_phase", ph, eph);
        chk_eq("repulse_mag", mg, emg);
        run_op(-131072, 0, 1'b1, 0, 0, ph, mg, lat);
        chk_eq("repulse_single_done", lat, LAT);
        chk_eq("b2b_phase", ph, 512);
        model(-131072, 0, eph, emg);
        chk_eq("b2b_mag", mg, emg);

        @(negedge clk);
        x_in  = 18'(40000);
        y_in  = 18'(-70000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("abort_busy", int'(busy), 0);
        chk_eq("abort_done", int'(done), 0);
        chk_eq("abort_phase", int'(phase), 0);
        chk_eq("abort_mag", int'(mag), 0);
        nd = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk_eq("abort_no_done", nd, 0);
        rst_n = 1'b1;
        run_op(92682, 92682, 1'b1, 0, 0, ph, mg, lat);
        model(92682, 92682, eph, emg);
        chk_eq("post_abort_lat", lat, LAT);
        chk_tol("post_abort_phase", ph, 128, 1);
        chk_eq("post_abort_mag", mg, emg);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
